// File: rtl/maze_pkg.sv
// Shared constants for the maze robot: movement codes, headings, motor patterns
// and the move sequencer state encoding.
package maze_pkg;

    localparam logic [3:0] CODE_NONE  = 4'b0000;
    localparam logic [3:0] CODE_NORTH = 4'b0001;
    localparam logic [3:0] CODE_EAST  = 4'b0011;
    localparam logic [3:0] CODE_SOUTH = 4'b0010;
    localparam logic [3:0] CODE_WEST  = 4'b0100;

    localparam logic [1:0] HDG_N = 2'd0;
    localparam logic [1:0] HDG_E = 2'd1;
    localparam logic [1:0] HDG_S = 2'd2;
    localparam logic [1:0] HDG_W = 2'd3;

    // {L_fwd, L_rev, R_fwd, R_rev}
    localparam logic [3:0] MOTOR_STOP  = 4'b0000;
    localparam logic [3:0] MOTOR_FWD   = 4'b1010;
    localparam logic [3:0] MOTOR_PIV_R = 4'b1001;
    localparam logic [3:0] MOTOR_PIV_L = 4'b0110;

    typedef enum logic [2:0] {
        ST_START,
        ST_IDLE,
        ST_TURN,
        ST_FWD,
        ST_SETTLE
    } seq_state_t;

    function automatic logic code_is_dir(input logic [3:0] code);
        return (code == CODE_NORTH) || (code == CODE_EAST) ||
               (code == CODE_SOUTH) || (code == CODE_WEST);
    endfunction

    function automatic logic [1:0] code_heading(input logic [3:0] code);
        logic [1:0] h;
        h = HDG_N;
        case (code)
            CODE_EAST:  h = HDG_E;
            CODE_SOUTH: h = HDG_S;
            CODE_WEST:  h = HDG_W;
            default:    h = HDG_N;
        endcase
        return h;
    endfunction

    // A 180-degree request resolves to right pivots; only delta 3 pivots left.
    function automatic logic [3:0] pivot_pattern(input logic [1:0] target,
                                                 input logic [1:0] heading);
        logic [1:0] delta;
        delta = target - heading;
        return (delta == 2'd3) ? MOTOR_PIV_L : MOTOR_PIV_R;
    endfunction

endpackage

// File: rtl/move_sequencer_if.sv
// Movement command handshake between the decision FSM and the move sequencer.
interface move_sequencer_if;
    logic       cmd_valid;
    logic [3:0] cmd_code;
    logic       cmd_ready;

    modport master (
        output cmd_valid,
        output cmd_code,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_code,
        output cmd_ready
    );
endinterface

// File: rtl/move_sequencer_phase_timer.sv
// Phase down-counter: loads duration-1 on phase entry and reports the final
// cycle (done) and the cycle before it (last).
module phase_timer #(
    parameter int CNT_W = 26
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             done,
    output logic             last
);

    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_val;
        end else if (count_q != '0) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign done = (count_q == '0);
    assign last = (count_q == CNT_W'(1));

endmodule

// File: rtl/move_sequencer.sv
// Move sequencer: turns one movement command into timed pivot, forward and
// settle phases on the motor bridge, tracking absolute heading.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_START  | one cycle after reset, raises the first sample_req
// ST_IDLE   | motors off, cmd_ready high, waiting for a command
// ST_TURN   | 90-degree pivot toward the latched target heading
// ST_FWD    | forward move of one cell
// ST_SETTLE | motors off dwell, sample_req on its last cycle
module move_sequencer
    import maze_pkg::*;
#(
    parameter int MOVE_CYCLES   = 50_000_000,
    parameter int TURN_CYCLES   = 25_000_000,
    parameter int SETTLE_CYCLES = 5_000_000,
    parameter int CNT_W         = 26
) (
    input  logic               clk,
    input  logic               rst,
    move_sequencer_if.slave    cmd,
    output logic [3:0]         motor,
    output logic [1:0]         heading,
    output logic               sample_req,
    output logic               busy,
    output logic               err
);

    seq_state_t state_q, state_d;
    logic [3:0] motor_q, motor_d;
    logic [1:0] heading_q, heading_d;
    logic [1:0] target_q, target_d;
    logic       err_q, err_d;
    logic       cmd_ready_q, cmd_ready_d;
    logic       busy_q, busy_d;
    logic       sample_req_q, sample_req_d;

    logic             phase_start;
    logic [CNT_W-1:0] load_val;
    logic             timer_done;
    logic             timer_last;

    phase_timer #(
        .CNT_W (CNT_W)
    ) u_phase_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (phase_start),
        .load_val (load_val),
        .done     (timer_done),
        .last     (timer_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_START;
            motor_q      <= MOTOR_STOP;
            heading_q    <= HDG_N;
            target_q     <= HDG_N;
            err_q        <= 1'b0;
            cmd_ready_q  <= 1'b0;
            busy_q       <= 1'b1;
            sample_req_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            motor_q      <= motor_d;
            heading_q    <= heading_d;
            target_q     <= target_d;
            err_q        <= err_d;
            cmd_ready_q  <= cmd_ready_d;
            busy_q       <= busy_d;
            sample_req_q <= sample_req_d;
        end
    end

    // Next state; outputs are then decoded from the next state so every
    // registered output lines up with the state it belongs to.
    always_comb begin
        state_d     = state_q;
        heading_d   = heading_q;
        target_d    = target_q;
        err_d       = err_q;
        phase_start = 1'b0;

        case (state_q)
            ST_START: begin
                if (sample_req_q) state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (cmd.cmd_valid && cmd_ready_q) begin
                    phase_start = 1'b1;
                    if (code_is_dir(cmd.cmd_code)) begin
                        target_d = code_heading(cmd.cmd_code);
                        state_d  = (target_d == heading_q) ? ST_FWD : ST_TURN;
                    end else begin
                        state_d = ST_SETTLE;
                        if (cmd.cmd_code != CODE_NONE) err_d = 1'b1;
                    end
                end
            end
            ST_TURN: begin
                if (timer_done) begin
                    phase_start = 1'b1;
                    heading_d   = (motor_q == MOTOR_PIV_L) ? heading_q - 2'd1
                                                           : heading_q + 2'd1;
                    state_d     = (heading_d == target_q) ? ST_FWD : ST_TURN;
                end
            end
            ST_FWD: begin
                if (timer_done) begin
                    phase_start = 1'b1;
                    state_d     = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (timer_done) state_d = ST_IDLE;
            end
            default: state_d = ST_START;
        endcase

        motor_d      = MOTOR_STOP;
        cmd_ready_d  = 1'b0;
        sample_req_d = 1'b0;
        busy_d       = (state_d != ST_IDLE);
        load_val     = '0;

        case (state_d)
            ST_START: sample_req_d = !sample_req_q;
            ST_IDLE:  cmd_ready_d  = 1'b1;
            ST_TURN: begin
                motor_d  = pivot_pattern(target_d, heading_d);
                load_val = CNT_W'(TURN_CYCLES - 1);
            end
            ST_FWD: begin
                motor_d  = MOTOR_FWD;
                load_val = CNT_W'(MOVE_CYCLES - 1);
            end
            ST_SETTLE: begin
                load_val     = CNT_W'(SETTLE_CYCLES - 1);
                sample_req_d = phase_start ? (SETTLE_CYCLES == 1) : timer_last;
            end
            default: ;
        endcase
    end

    assign cmd.cmd_ready = cmd_ready_q;
    assign motor         = motor_q;
    assign heading       = heading_q;
    assign sample_req    = sample_req_q;
    assign busy          = busy_q;
    assign err           = err_q;

endmodule

// File: doc/move_sequencer.md
MOVE_SEQUENCER -- requirements
Module: move_sequencer

Interface
REQ-001 Parameter MOVE_CYCLES, default 50_000_000: length of one forward cell move, in clk cycles (>=1).
REQ-002 Parameter TURN_CYCLES, default 25_000_000: length of one 90-degree pivot, in clk cycles (>=1).
REQ-003 Parameter SETTLE_CYCLES, default 5_000_000: motors-off dwell before the next sensor decision (>=1).
REQ-004 Parameter CNT_W, default 26: phase counter width; must hold max(parameters)-1.
REQ-005 clk  in  1  single clock; all logic on its rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 cmd_valid  in  1  movement command present.
REQ-008 cmd_code  in  4  movement code: 0000 NONE, 0001 NORTH, 0011 EAST, 0010 SOUTH, 0100 WEST; all other codes illegal.
REQ-009 cmd_ready  out  1  sequencer accepts a command this cycle.
REQ-010 motor  out  4  {L_fwd,L_rev,R_fwd,R_rev}.
REQ-011 heading  out  2  current absolute heading: 0 N, 1 E, 2 S, 3 W.
REQ-012 sample_req  out  1  one-cycle pulse; enables one decision step of the sensor/decision FSM.
REQ-013 busy  out  1  high in every state except IDLE.
REQ-014 err  out  1  sticky flag; set by an illegal code.

Function
REQ-015 States: START, IDLE, TURN, FWD, SETTLE; all outputs registered.
REQ-016 START: lasts one cycle after reset release, drives sample_req=1, then goes to IDLE.
REQ-017 IDLE: cmd_ready=1 and motor=0000; a transfer occurs when cmd_valid && cmd_ready at a rising edge.
REQ-018 On a transfer, the target heading is latched. The next state is:
- TURN if target != heading;
- FWD if target == heading;
- SETTLE for NONE or an illegal code.
REQ-019 An illegal code sets err=1; err clears only on rst.
REQ-020 delta = (target - heading) mod 4. Direction of each pivot:
- delta 1 or 2: right pivot, motor=1001;
- delta 3: left pivot, motor=0110.
REQ-021 Each pivot lasts exactly TURN_CYCLES cycles. On its last cycle, heading updates by +1 (right) or -1 (left) mod 4.
REQ-022 After a pivot, the block re-evaluates: TURN again if heading != target, else FWD. A 180-degree request is therefore two right pivots, 2*TURN_CYCLES total.
REQ-023 FWD: motor=1010 for exactly MOVE_CYCLES cycles, then SETTLE.
REQ-024 SETTLE: motor=0000 for exactly SETTLE_CYCLES cycles. On the last cycle, sample_req=1 for one cycle, then IDLE.
REQ-025 Latency: for a transfer at edge k, the motor pattern is visible after edge k+1 and cmd_ready is 0 after edge k+1.
REQ-026 The phase counter loads duration-1 on phase entry, decrements each cycle, and the phase ends at count 0. No phase is ever shorter or longer than its parameter.
REQ-027 cmd_code and cmd_valid are ignored outside IDLE; no command is queued.
REQ-028 motor never shows both fwd and rev bits of the same wheel; only 0000, 1010, 1001 and 0110 are legal values.
REQ-029 sample_req is never high in two consecutive cycles.

Reset
REQ-030 rst=1 at any edge, including mid-TURN or mid-FWD, takes effect on that edge:
- state=START;
- motor=0000, heading=0 (N);
- err=0, counter=0;
- cmd_ready=0, busy=1, sample_req=0.
REQ-031 The first sample_req pulse occurs in the first cycle after rst deasserts.

Structure
REQ-032 Shared package maze_pkg SHALL hold:
- movement code constants;
- heading encodings;
- motor pattern constants (STOP, FWD, PIV_R, PIV_L);
- the sequencer state encoding.
The decision FSM uses the same code constants.
REQ-033 One sub-module, phase_timer (load value, load strobe, done), SHALL implement the down-counter. Everything else stays in move_sequencer.

Verification (MOVE_CYCLES=8, TURN_CYCLES=4, SETTLE_CYCLES=2)
REQ-034 Release rst -> sample_req high exactly one cycle; then cmd_ready=1, heading=0, motor=0000.
REQ-035 Heading N, cmd 0001 -> motor=1010 for 8 cycles, then 0000 for 2 cycles with sample_req on the 2nd; then cmd_ready=1, heading=0.
REQ-036 Heading N, cmd 0010 -> motor=1001 for 8 cycles (heading 1 after cycle 4, 2 after cycle 8), then 1010 for 8, then settle 2; final heading=2.
REQ-037 Heading N, cmd 0100 -> motor=0110 for 4 cycles, heading=3, then 1010 for 8.
REQ-038 Cmd 0101 -> err=1, motor stays 0000, sample_req after 2 cycles; err stays 1 through a following legal command.
REQ-039 rst asserted on cycle 2 of a pivot -> next cycle motor=0000, heading=0, err=0; then the START pulse follows.
